banked_ecc_multiport_memory: RTL and testbench
==============================================

# banked_ecc_multiport_memory

Parametrised successor to the two-port banked memory: NUM_PORTS requesters share one clock domain and NUM_BANK single-ported banks. Per-bank round-robin arbitration resolves conflicts, and every word is stored as a Hamming SEC codeword. Read data returns after a fixed READ_LATENCY with single-bit correction and an error flag. It sits between the port-side masters and the storage array, replacing the fixed A/B dual-port top.

## Interface
- WIDTH, 8, data bits per word
- CODE_WIDTH, 12, stored codeword bits; must satisfy 2**(CODE_WIDTH-WIDTH) >= CODE_WIDTH+1
- ADDR_WIDTH, 10, word address bits; DEPTH = 2**ADDR_WIDTH total words
- NUM_BANK, 4, banks; power of two, >= 2
- NUM_PORTS, 4, requesting ports, >= 2
- READ_LATENCY, 3, cycles from grant edge to o_rvalid; >= 1
- i_clk  in  1  single clock; all logic on its rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_req  in  NUM_PORTS  per-port request
- i_we  in  NUM_PORTS  1 = write, 0 = read, qualified by i_req
- i_addr  in  NUM_PORTS*ADDR_WIDTH  packed per-port word address; port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- i_din  in  NUM_PORTS*WIDTH  packed per-port write data
- i_inj_err  in  NUM_PORTS  on a granted write, stored codeword bit 2 (Hamming position 3) is inverted
- o_gnt  out  NUM_PORTS  combinational grant; the request is accepted at this edge
- o_rvalid  out  NUM_PORTS  read data valid, one cycle per granted read
- o_dout  out  NUM_PORTS*WIDTH  corrected read data, packed like i_din
- o_ecc_err  out  NUM_PORTS  corrected single-bit error on this read, valid with o_rvalid

## Operation
- Bank = addr[log2(NUM_BANK)-1:0]; row = remaining upper bits.
- Each bank grants at most one port per cycle. Per-bank round-robin pointer rr[b] (reset 0). Search starts at rr[b] and ascends with wrap. After a grant to port p, rr[b] = (p+1) mod NUM_PORTS. A bank with no requests keeps its pointer.
- Requests to different banks are granted in the same cycle. Any number of ports can be granted per cycle, up to NUM_BANK.
- Ungranted requesters hold i_req, i_we, i_addr and i_din stable until o_gnt. The block keeps no request queue.
- Granted write: the bank stores ecc_encode(din) at the edge, XOR bit 2 if i_inj_err. No response.
- Granted read: the bank reads the codeword, then ecc_decode takes the syndrome. Syndrome 0: data unchanged, o_ecc_err = 0. Syndrome nonzero and <= CODE_WIDTH: flip that position, o_ecc_err = 1. Otherwise: pass data uncorrected, o_ecc_err = 1.
- Read-after-write to the same address in a later cycle returns the new data. Reads and writes to the same bank can never collide in one cycle because of arbitration.
- Memory contents are not reset. A read of an unwritten location returns undefined data, and the bench excludes it.

## Timing
- Grant is combinational from i_req and rr in the same cycle. The write or read launch happens at that rising edge.
- Read granted at edge N: o_rvalid, o_dout and o_ecc_err are valid in the cycle after edge N+READ_LATENCY-1. The port's response pipeline is fully pipelined, so one read per port per cycle is sustained.
- Responses per port return in grant order.
- Reset values: o_rvalid = 0, o_dout = 0, o_ecc_err = 0, all rr = 0. o_gnt is 0 while i_rst_n = 0.
- Reset asserted mid-operation clears all in-flight reads immediately (asynchronously). No o_rvalid appears for them after release.
- First grant is possible at the first rising edge after i_rst_n deasserts.

## Structure
- The package holds:
  - the Hamming position map (parity at powers of two);
  - the functions ecc_encode(WIDTH→CODE_WIDTH) and ecc_decode (returns data and error flag);
  - the constant BANK_BITS = $clog2(NUM_BANK).
- Sub-module memory_bank: one single-port CODE_WIDTH × DEPTH/NUM_BANK array with a registered read. It is instantiated NUM_BANK times.
- The top holds the arbiters, the crossbar and the per-port READ_LATENCY-1 stage valid/data/tag shift registers. The ECC decode sits at the final stage.

## Test plan
- Reset: hold i_rst_n = 0 for 3 cycles → all outputs 0. Release, then port0 writes 0xA5 to 0x010 and reads it back → o_dout[0] = 0xA5 exactly READ_LATENCY cycles after the read grant, o_ecc_err = 0.
- Bank parallelism: ports 0–3 read addresses 0x000, 0x001, 0x002 and 0x003 in one cycle → o_gnt = 4'b1111, four o_rvalid in the same cycle.
- Conflict: ports 0–3 all request bank 0 (0x004, 0x008, 0x00C, 0x010) and hold → grants on consecutive cycles 0, 1, 2, 3. Repeat with rr[0] at 1 → order 1, 2, 3, 0.
- ECC: port1 writes 0x3C to 0x020 with i_inj_err = 1, then reads it → o_dout = 0x3C, o_ecc_err = 1. A clean rewrite, then a read → o_ecc_err = 0.
- Back-to-back reads: port2 issues 8 consecutive reads of preloaded addresses 0x100–0x107 → 8 consecutive o_rvalid in order, with no bubbles.
- Reset mid-flight: grant a read, assert i_rst_n one cycle later → no o_rvalid after release, and rr is back to 0.

Source files
------------

// File: rtl/banked_ecc_multiport_memory_pkg.sv
// Shared ECC helpers for the banked multiport memory: Hamming SEC encode/decode
// over a generic maximum word, with parity bits at power-of-two positions.
package banked_ecc_multiport_memory_pkg;

  localparam int MAX_W        = 64;
  localparam int DEF_NUM_BANK = 4;
  localparam int BANK_BITS    = $clog2(DEF_NUM_BANK);

  typedef logic [MAX_W-1:0] word_t;

  typedef struct packed {
    word_t data;
    logic  err;
  } ecc_dec_t;

  // Hamming positions are 1-based; powers of two carry parity.
  function automatic logic is_parity_pos(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  function automatic word_t ecc_encode(input word_t data, input int w, input int cw);
    word_t code;
    int    k;
    code = '0;
    k    = 0;
    for (int pos = 1; pos <= MAX_W; pos++) begin
      if (pos <= cw && !is_parity_pos(pos)) begin
        if (k < w) code[pos-1] = data[k];
        k++;
      end
    end
    for (int i = 0; i < 7; i++) begin
      logic par;
      par = 1'b0;
      for (int pos = 1; pos <= MAX_W; pos++) begin
        if (pos <= cw && (pos & (1 << i)) != 0) par ^= code[pos-1];
      end
      if ((1 << i) <= cw) code[(1 << i) - 1] = par;
    end
    return code;
  endfunction

  function automatic ecc_dec_t ecc_decode(input word_t code_in, input int w, input int cw);
    ecc_dec_t res;
    word_t    code;
    int       syn;
    int       k;
    code = code_in;
    syn  = 0;
    for (int pos = 1; pos <= MAX_W; pos++) begin
      if (pos <= cw && code[pos-1]) syn = syn ^ pos;
    end
    // Out-of-range syndromes (multi-bit damage) leave the word as stored.
    if (syn != 0 && syn <= cw) code[syn-1] = ~code[syn-1];
    res.err  = (syn != 0);
    res.data = '0;
    k        = 0;
    for (int pos = 1; pos <= MAX_W; pos++) begin
      if (pos <= cw && !is_parity_pos(pos)) begin
        if (k < w) res.data[k] = code[pos-1];
        k++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/banked_ecc_multiport_memory_memory_bank.sv
// One single-port codeword bank with a registered read; contents are not reset.
module memory_bank
  import banked_ecc_multiport_memory_pkg::*;
#(
  parameter int CODE_WIDTH = 12,
  parameter int ROW_W      = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ROW_W-1:0]      row,
  input  logic [CODE_WIDTH-1:0] wdata,
  output logic [CODE_WIDTH-1:0] rdata
);

  logic [CODE_WIDTH-1:0] mem [2**ROW_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[row] <= wdata;
      else    rdata    <= mem[row];
    end
  end

endmodule

// File: rtl/banked_ecc_multiport_memory.sv
// Multiport front end over NUM_BANK ECC banks: per-bank round-robin arbiters,
// port/bank crossbar, and per-port read-return pipelines with final-stage decode.
module banked_ecc_multiport_memory
  import banked_ecc_multiport_memory_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CODE_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_BANK     = DEF_NUM_BANK,
  parameter int NUM_PORTS    = 4,
  parameter int READ_LATENCY = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NUM_PORTS-1:0]            i_req,
  input  logic [NUM_PORTS-1:0]            i_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_PORTS*WIDTH-1:0]      i_din,
  input  logic [NUM_PORTS-1:0]            i_inj_err,
  output logic [NUM_PORTS-1:0]            o_gnt,
  output logic [NUM_PORTS-1:0]            o_rvalid,
  output logic [NUM_PORTS*WIDTH-1:0]      o_dout,
  output logic [NUM_PORTS-1:0]            o_ecc_err
);

  localparam int BANK_W = $clog2(NUM_BANK);
  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int ROW_W  = ADDR_WIDTH - BANK_W;
  localparam int STAGES = READ_LATENCY;

  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  gnt;
  logic [NUM_BANK-1:0]   bank_en;
  logic [NUM_BANK-1:0]   bank_we;
  logic [PORT_W-1:0]     rr         [NUM_BANK];
  logic [PORT_W-1:0]     sel        [NUM_BANK];
  logic [ROW_W-1:0]      bank_row   [NUM_BANK];
  logic [CODE_WIDTH-1:0] bank_wdata [NUM_BANK];
  logic [CODE_WIDTH-1:0] bank_rdata [NUM_BANK];
  logic                  unused_enc;
  logic                  unused_dec;

  // Arbitration: each bank scans ports upward from its pointer, with wrap.
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    req     = i_req & {NUM_PORTS{i_rst_n}};
    gnt     = '0;
    bank_en = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      sel[b] = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = int'(rr[b]) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!found && req[idx] && (int'(i_addr[idx*ADDR_WIDTH +: BANK_W]) == b)) begin
          found    = 1'b1;
          sel[b]   = PORT_W'(idx);
          gnt[idx] = 1'b1;
        end
      end
      bank_en[b] = found;
    end
  end

  assign o_gnt = gnt;

  always_comb begin
    int    s;
    word_t enc;
    s          = 0;
    enc        = '0;
    unused_enc = 1'b0;
    for (int b = 0; b < NUM_BANK; b++) begin
      s             = int'(sel[b]);
      bank_we[b]    = i_we[s];
      bank_row[b]   = i_addr[s*ADDR_WIDTH+BANK_W +: ROW_W];
      enc           = ecc_encode(word_t'(i_din[s*WIDTH +: WIDTH]), WIDTH, CODE_WIDTH);
      bank_wdata[b] = enc[CODE_WIDTH-1:0] ^ ({{(CODE_WIDTH-1){1'b0}}, i_inj_err[s]} << 2);
      unused_enc    = unused_enc ^ (^enc[MAX_W-1:CODE_WIDTH]);
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    memory_bank #(
      .CODE_WIDTH (CODE_WIDTH),
      .ROW_W      (ROW_W)
    ) u_bank (
      .clk   (i_clk),
      .en    (bank_en[b]),
      .we    (bank_we[b]),
      .row   (bank_row[b]),
      .wdata (bank_wdata[b]),
      .rdata (bank_rdata[b])
    );
  end

  // Stage p0: grant edge; the bank launches its read, the port remembers which bank.
  logic [NUM_PORTS-1:0]  vld_p0;
  logic [BANK_W-1:0]     tag_p0  [NUM_PORTS];
  logic [CODE_WIDTH-1:0] code_p0 [NUM_PORTS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p0 <= '0;
      for (int b = 0; b < NUM_BANK; b++) rr[b] <= '0;
    end else begin
      vld_p0 <= gnt & ~i_we;
      for (int b = 0; b < NUM_BANK; b++) begin
        if (bank_en[b]) rr[b] <= (sel[b] == PORT_W'(NUM_PORTS - 1)) ? '0 : sel[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) tag_p0[p] <= i_addr[p*ADDR_WIDTH +: BANK_W];
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) code_p0[p] = bank_rdata[tag_p0[p]];
  end

  logic [NUM_PORTS-1:0]  vld_out;
  logic [CODE_WIDTH-1:0] code_out [NUM_PORTS];

  if (STAGES == 1) begin : g_direct
    assign vld_out = vld_p0;
    always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) code_out[p] = code_p0[p];
    end
  end else begin : g_pipe
    // Stages p1..: bank codeword captured off the crossbar, then delayed to the return slot.
    logic [NUM_PORTS-1:0]  vld_pn  [STAGES-1];
    logic [CODE_WIDTH-1:0] code_pn [STAGES-1][NUM_PORTS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int s = 0; s < STAGES - 1; s++) vld_pn[s] <= '0;
      end else begin
        vld_pn[0] <= vld_p0;
        for (int s = 1; s < STAGES - 1; s++) vld_pn[s] <= vld_pn[s-1];
      end
    end

    always_ff @(posedge i_clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        code_pn[0][p] <= code_p0[p];
        for (int s = 1; s < STAGES - 1; s++) code_pn[s][p] <= code_pn[s-1][p];
      end
    end

    assign vld_out = vld_pn[STAGES-2];
    always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) code_out[p] = code_pn[STAGES-2][p];
    end
  end

  // Final stage: decode and correct; outputs are held at zero outside a valid beat.
  always_comb begin
    ecc_dec_t dec;
    dec        = '0;
    o_dout     = '0;
    o_ecc_err  = '0;
    unused_dec = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      dec = ecc_decode(word_t'(code_out[p]), WIDTH, CODE_WIDTH);
      o_dout[p*WIDTH +: WIDTH] = vld_out[p] ? dec.data[WIDTH-1:0] : '0;
      o_ecc_err[p]             = vld_out[p] & dec.err;
      unused_dec               = unused_dec ^ (^dec.data[MAX_W-1:WIDTH]);
    end
  end

  assign o_rvalid = vld_out;

endmodule

// File: tb/tb_banked_ecc_multiport_memory.sv
// Directed bench for banked_ecc_multiport_memory with a per-port read scoreboard.
module tb_banked_ecc_multiport_memory;

  localparam int NP = 4;
  localparam int W  = 8;
  localparam int AW = 10;
  localparam int RL = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     i_req, i_we, i_inj_err;
  logic [NP*AW-1:0]  i_addr;
  logic [NP*W-1:0]   i_din;
  logic [NP-1:0]     o_gnt, o_rvalid, o_ecc_err;
  logic [NP*W-1:0]   o_dout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W:0]  exp_q [NP][$];
  int          lat_q [NP][$];
  logic [W-1:0] model     [int];
  logic         err_model [int];

  banked_ecc_multiport_memory #(
    .WIDTH(W), .CODE_WIDTH(12), .ADDR_WIDTH(AW), .NUM_BANK(4),
    .NUM_PORTS(NP), .READ_LATENCY(RL)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_din(i_din), .i_inj_err(i_inj_err), .o_gnt(o_gnt), .o_rvalid(o_rvalid),
    .o_dout(o_dout), .o_ecc_err(o_ecc_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: match each o_rvalid against the scoreboard and its due cycle.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (o_rvalid[p]) begin
        if (exp_q[p].size() == 0 || lat_q[p].size() == 0) begin
          check($sformatf("unexpected_rvalid_p%0d", p), 32'(o_rvalid[p]), 32'd0);
        end else begin
          logic [W:0] e;
          int         due;
          e   = exp_q[p].pop_front();
          due = lat_q[p].pop_front();
          check($sformatf("dout_p%0d", p), 32'(o_dout[p*W +: W]), 32'(e[W-1:0]));
          check($sformatf("ecc_err_p%0d", p), 32'(o_ecc_err[p]), 32'(e[W]));
          check($sformatf("latency_p%0d", p), 32'(cyc), 32'(due));
        end
      end else if (lat_q[p].size() > 0 && lat_q[p][0] < cyc) begin
        check($sformatf("missing_rvalid_p%0d", p), 32'(o_rvalid[p]), 32'd1);
        void'(lat_q[p].pop_front());
        if (exp_q[p].size() > 0) void'(exp_q[p].pop_front());
      end
      if (o_gnt[p] && !i_we[p]) lat_q[p].push_back(cyc + RL);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [W-1:0] d, input logic inj);
    i_req[p] = 1'b1;
    i_we[p] = we;
    i_addr[p*AW +: AW] = a;
    i_din[p*W +: W] = d;
    i_inj_err[p] = inj;
    if (we) begin
      model[int'(a)] = d;
      err_model[int'(a)] = inj;
    end else begin
      exp_q[p].push_back({err_model[int'(a)], model[int'(a)]});
    end
  endtask

  task automatic clear_port(input int p);
    i_req[p] = 1'b0;
    i_we[p] = 1'b0;
    i_inj_err[p] = 1'b0;
  endtask

  task automatic single(input string tag, input int p, input logic we,
                        input logic [AW-1:0] a, input logic [W-1:0] d, input logic inj);
    set_port(p, we, a, d, inj);
    #1;
    check(tag, 32'(o_gnt), 32'(1 << p));
    tick();
    clear_port(p);
  endtask

  task automatic conflict(input int first);
    logic [AW-1:0] al [NP];
    al[0] = 10'h004; al[1] = 10'h008; al[2] = 10'h00C; al[3] = 10'h010;
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, al[p], 8'h00, 1'b0);
    for (int i = 0; i < NP; i++) begin
      int q;
      q = (first + i) % NP;
      #1;
      check($sformatf("conflict_from%0d_step%0d", first, i), 32'(o_gnt), 32'(1 << q));
      tick();
      clear_port(q);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = '1; i_we = '0; i_inj_err = '0; i_addr = '0; i_din = '0;
    repeat (3) tick();
    check("rst_gnt", 32'(o_gnt), 32'd0);
    check("rst_rvalid", 32'(o_rvalid), 32'd0);
    check("rst_dout", o_dout, 32'd0);
    check("rst_ecc_err", 32'(o_ecc_err), 32'd0);
    i_req = '0;
    rst_n = 1'b1;
    tick();

    single("wr_a5_gnt", 0, 1'b1, 10'h010, 8'hA5, 1'b0);
    single("rd_a5_gnt", 0, 1'b0, 10'h010, 8'h00, 1'b0);
    repeat (RL + 1) tick();

    for (int p = 0; p < NP; p++) set_port(p, 1'b1, AW'(p), W'(8'h11 * (p + 1)), 1'b0);
    #1;
    check("par_wr_gnt", 32'(o_gnt), 32'hF);
    tick();
    for (int p = 0; p < NP; p++) clear_port(p);
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, AW'(p), 8'h00, 1'b0);
    #1;
    check("par_rd_gnt", 32'(o_gnt), 32'hF);
    tick();
    for (int p = 0; p < NP; p++) clear_port(p);
    repeat (RL + 1) tick();

    single("ecc_wr_inj", 1, 1'b1, 10'h020, 8'h3C, 1'b1);
    single("ecc_rd_inj", 1, 1'b0, 10'h020, 8'h00, 1'b0);
    single("ecc_wr_clean", 1, 1'b1, 10'h020, 8'h3C, 1'b0);
    single("ecc_rd_clean", 1, 1'b0, 10'h020, 8'h00, 1'b0);
    repeat (RL + 1) tick();

    single("pre_004", 0, 1'b1, 10'h004, 8'h4E, 1'b0);
    single("pre_008", 0, 1'b1, 10'h008, 8'h81, 1'b0);
    single("pre_00c", 0, 1'b1, 10'h00C, 8'hC3, 1'b0);
    single("pre_010", 0, 1'b1, 10'h010, 8'h5A, 1'b0);
    for (int i = 0; i < 8; i++)
      single($sformatf("pre_10%0d", i), 2, 1'b1, AW'(10'h100 + i), W'(8'h80 + 7 * i), 1'b0);

    for (int i = 0; i < 8; i++) begin
      set_port(2, 1'b0, AW'(10'h100 + i), 8'h00, 1'b0);
      #1;
      check($sformatf("b2b_gnt_%0d", i), 32'(o_gnt), 32'h4);
      tick();
    end
    clear_port(2);
    repeat (RL + 1) tick();

    single("mid_rd_gnt", 2, 1'b0, 10'h100, 8'h00, 1'b0);
    rst_n = 1'b0;
    exp_q[2].delete();
    lat_q[2].delete();
    #1;
    check("mid_rst_rvalid", 32'(o_rvalid), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < RL + 3; i++) begin
      tick();
      check($sformatf("mid_no_rvalid_%0d", i), 32'(o_rvalid), 32'd0);
    end

    conflict(0);
    repeat (RL + 1) tick();
    single("rr_to_1", 0, 1'b0, 10'h004, 8'h00, 1'b0);
    conflict(1);
    repeat (RL + 3) tick();

    for (int p = 0; p < NP; p++) begin
      check($sformatf("drain_exp_p%0d", p), 32'(exp_q[p].size()), 32'd0);
      check($sformatf("drain_lat_p%0d", p), 32'(lat_q[p].size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
